lcd_bus_scheduler: RTL and testbench

Sequences all traffic onto the ILI9341 8-bit parallel write path. It sits between the PPU pixel stream and CPU command port on one side and the byte-wide bus writer on the other. Per frame, it emits the column/row window and memory-write opcode, then serialises RGB565 pixels into hi/lo bytes. It grants CPU command groups atomically, and only between frames during vblank.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_out_reg.sv | 33 +++
 rtl/lcd_bus_scheduler.sv | 145 ++++++++++++++
 tb/tb_lcd_bus_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared ILI9341 opcodes, scheduler states, bus byte type and window-byte lookup
package lcd_pkg;

    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] PASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;
    localparam int WIN_LEN = 11;

    typedef enum logic [2:0] {IDLE, WIN, PIX_HI, PIX_LO, CMD} state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    // Window preamble: CASET 0,0,w-1 then PASET 0,0,h-1 then RAMWR
    function automatic lcd_byte_t win_byte(input logic [3:0] idx, input logic [15:0] w_m1,
                                           input logic [15:0] h_m1);
        case (idx)
            4'd0:    return '{1'b0, CASET};
            4'd3:    return '{1'b1, w_m1[15:8]};
            4'd4:    return '{1'b1, w_m1[7:0]};
            4'd5:    return '{1'b0, PASET};
            4'd8:    return '{1'b1, h_m1[15:8]};
            4'd9:    return '{1'b1, h_m1[7:0]};
            4'd10:   return '{1'b0, RAMWR};
            default: return '{1'b1, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/lcd_out_reg.sv
// lcd_out_reg: one-entry valid/ready holding register feeding the bus writer
//   load_o           register may take a new byte this cycle (empty or being accepted)
//   in_valid_i/data  byte offered by the scheduler
//   bus_*            valid/ready handshake toward the bus writer
module lcd_out_reg (
    input  logic       clk,
    input  logic       rst_n,
    output logic       load_o,
    input  logic       in_valid_i,
    input  logic [8:0] in_data_i,
    input  logic       bus_ready_i,
    output logic       bus_valid_o,
    output logic [8:0] bus_data_o
);

    logic       valid_q;
    logic [8:0] data_q;

    assign load_o      = !valid_q || bus_ready_i;
    assign bus_valid_o = valid_q;
    assign bus_data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: serialises window preamble, RGB565 pixels and vblank CPU command groups onto the ILI9341 byte bus
//   enable/vblank         writer ready / between-frames level
//   pix_*                 pixel stream (pix_sof marks first pixel of a frame)
//   cmd_*                 {rs,byte} command stream, cmd_last closes an atomic group
//   bus_*                 {rs,byte} toward the bus writer
//   frame_done/sync_err   end-of-frame pulse, sticky SOF misalignment flag (err_clr clears)
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        vblank,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_data,
    input  logic        cmd_last,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [8:0]  bus_data,
    output logic        frame_done,
    output logic        sync_err,
    input  logic        err_clr
);

    localparam int NPIX = SCREEN_W * SCREEN_H;
    localparam int CW = NPIX > 1 ? $clog2(NPIX) : 1;
    localparam logic [15:0] W_M1 = 16'(SCREEN_W - 1);
    localparam logic [15:0] H_M1 = 16'(SCREEN_H - 1);

    state_t          st_q, st_d;
    logic [3:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      lat_q, lat_d;
    logic            fd_q, fd_d, err_q, err_set;
    logic            ld, emit;
    lcd_byte_t       ob;

    lcd_out_reg u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_o     (ld),
        .in_valid_i (emit),
        .in_data_i  (ob),
        .bus_ready_i(bus_ready),
        .bus_valid_o(bus_valid),
        .bus_data_o (bus_data)
    );

    always_comb begin
        st_d      = st_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        fd_d      = 1'b0;
        err_set   = 1'b0;
        emit      = 1'b0;
        ob        = '0;
        pix_ready = 1'b0;
        cmd_ready = 1'b0;
        case (st_q)
            IDLE: if (enable) begin
                if (vblank && cmd_valid) begin
                    st_d = CMD;
                end else if (pix_valid && pix_sof) begin
                    st_d  = WIN;
                    idx_d = '0;
                    cnt_d = '0;
                end else if (pix_valid && ld) begin
                    // stray mid-frame pixel with no frame open: drop it and flag
                    pix_ready = 1'b1;
                    err_set   = 1'b1;
                end
            end
            WIN: if (ld) begin
                emit  = 1'b1;
                ob    = win_byte(idx_q, W_M1, H_M1);
                idx_d = idx_q + 1'b1;
                if (idx_q == 4'(WIN_LEN - 1)) st_d = PIX_HI;
            end
            PIX_HI: if (pix_valid) begin
                if (pix_sof && cnt_q != '0) begin
                    // new frame started early: leave the SOF pixel pending and resync
                    err_set = 1'b1;
                    st_d    = WIN;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (ld) begin
                    emit  = 1'b1;
                    ob    = '{1'b1, pix_data[15:8]};
                    lat_d = pix_data[7:0];
                    st_d  = PIX_LO;
                end
            end
            PIX_LO: if (ld) begin
                emit      = 1'b1;
                ob        = '{1'b1, lat_q};
                pix_ready = 1'b1;
                if (cnt_q == CW'(NPIX - 1)) begin
                    fd_d = 1'b1;
                    st_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    st_d  = PIX_HI;
                end
            end
            CMD: if (cmd_valid && ld) begin
                emit      = 1'b1;
                ob        = cmd_data;
                cmd_ready = 1'b1;
                if (cmd_last) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            idx_q <= '0;
            cnt_q <= '0;
            lat_q <= '0;
            fd_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            lat_q <= lat_d;
            fd_q  <= fd_d;
            err_q <= err_set || (err_q && !err_clr);
        end
    end

    assign frame_done = fd_q;
    assign sync_err   = err_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler: randomized stream-level checks of the LCD bus scheduler against a frame model
module tb_lcd_bus_scheduler;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clk = 0, rst_n = 0, enable = 0, vblank = 0;
    logic        pix_valid = 0, pix_sof = 0, cmd_valid = 0, cmd_last = 0;
    logic        bus_ready = 1, err_clr = 0;
    logic [15:0] pix_data = 0;
    logic [8:0]  cmd_data = 0;
    logic        pix_ready, cmd_ready, bus_valid, frame_done, sync_err;
    logic [8:0]  bus_data;

    int tests = 0, fails = 0;
    logic [8:0]  got[$], exp[$];
    logic [16:0] pq[$];
    logic [9:0]  cq[$];
    int exp_fd, fd_cnt, stab_err, pr_cnt;
    bit exp_err, prev_stall;
    logic [8:0] prev_d;

    lcd_bus_scheduler #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vblank(vblank),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_data(bus_data),
        .frame_done(frame_done), .sync_err(sync_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!bus_valid || bus_data !== prev_d)) stab_err++;
            prev_stall = bus_valid && !bus_ready;
            prev_d = bus_data;
            if (bus_valid && bus_ready) got.push_back(bus_data);
            if (frame_done) fd_cnt++;
        end
    end

    function automatic void push_win();
        logic [15:0] wm, hm;
        wm = 16'(W - 1);
        hm = 16'(H - 1);
        exp.push_back({1'b0, 8'h2A});
        exp.push_back(9'h100);
        exp.push_back(9'h100);
        exp.push_back({1'b1, wm[15:8]});
        exp.push_back({1'b1, wm[7:0]});
        exp.push_back({1'b0, 8'h2B});
        exp.push_back(9'h100);
        exp.push_back(9'h100);
        exp.push_back({1'b1, hm[15:8]});
        exp.push_back({1'b1, hm[7:0]});
        exp.push_back({1'b0, 8'h2C});
    endfunction

    // Frame-level behaviour: open a frame on SOF, restart on early SOF, drop strays outside a frame
    function automatic void model();
        bit in_frame = 0;
        int cnt = 0;
        exp_fd = 0;
        exp_err = 0;
        foreach (pq[i]) begin
            bit sof = pq[i][16];
            if (!in_frame) begin
                if (!sof) begin
                    exp_err = 1;
                    continue;
                end
                push_win();
                in_frame = 1;
                cnt = 0;
            end else if (sof && cnt != 0) begin
                exp_err = 1;
                push_win();
                cnt = 0;
            end
            exp.push_back({1'b1, pq[i][15:8]});
            exp.push_back({1'b1, pq[i][7:0]});
            cnt++;
            if (cnt == N) begin
                exp_fd++;
                in_frame = 0;
            end
        end
    endfunction

    function automatic int first_diff();
        int m = got.size() < exp.size() ? got.size() : exp.size();
        for (int i = 0; i < m; i++) if (got[i] !== exp[i]) return i;
        return got.size() != exp.size() ? m : -1;
    endfunction

    function automatic void push_frame(input bit rnd, input logic [15:0] base);
        for (int i = 0; i < N; i++) pq.push_back({1'(i == 0), rnd ? 16'($urandom) : base + 16'(i)});
    endfunction

    task automatic clear();
        got.delete();
        exp.delete();
        pq.delete();
        cq.delete();
        fd_cnt = 0;
        stab_err = 0;
        pr_cnt = 0;
    endtask

    // mode 0: ready high, 1: random ready, 2: ready pattern 1,0,0,1
    task automatic drive(input int mode, input bit gaps, input int limit, input bit must_finish);
        int cyc = 0;
        bit pv = 0, ph, ch;
        while ((pq.size() > 0 || cq.size() > 0 || bus_valid) && cyc < limit) begin
            @(negedge clk);
            bus_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) :
                        (cyc % 4 == 1 || cyc % 4 == 2) ? 1'b0 : 1'b1;
            if (!pv && pq.size() > 0) pv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_valid = pv;
            if (pq.size() > 0) {pix_sof, pix_data} = pq[0];
            else pix_sof = 0;
            cmd_valid = cq.size() > 0;
            if (cmd_valid) {cmd_last, cmd_data} = cq[0];
            #2;
            ph = pix_ready;
            ch = cmd_ready;
            @(posedge clk);
            cyc++;
            if (ph) begin
                void'(pq.pop_front());
                pv = 0;
                pr_cnt++;
            end
            if (ch) void'(cq.pop_front());
        end
        if (must_finish) begin
            tests++;
            if (cyc >= limit) begin
                fails++;
                $display("FAIL drive_timeout: %0d cycles used, required under %0d", cyc, limit);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        pix_valid = 0;
        pix_sof = 0;
        cmd_valid = 0;
        cmd_last = 0;
        bus_ready = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_stream(input string name);
        int d = first_diff();
        tests++;
        if (d >= 0) begin
            fails++;
            $display("FAIL %s: byte %0d got %h (count %0d) required %h (count %0d)",
                     name, d, got[d], got.size(), exp[d], exp.size());
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus_ready = 1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus_valid, bus_data, pix_ready, cmd_ready, frame_done, sync_err} !== 14'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0",
                     {bus_valid, bus_data, pix_ready, cmd_ready, frame_done, sync_err});
        end
        rst_n = 1;
    endtask

    task automatic test_enable_low();
        int bad = 0;
        enable = 0;
        pix_valid = 1;
        pix_sof = 1;
        pix_data = 16'hF800;
        repeat (6) begin
            @(negedge clk);
            #2;
            if (pix_ready || bus_valid) bad++;
        end
        pix_valid = 0;
        pix_sof = 0;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL enable_low: %0d cycles with grant or bus activity, required 0", bad);
        end
        enable = 1;
    endtask

    task automatic test_basic_frame();
        clear();
        push_frame(0, 16'hF800);
        model();
        drive(0, 0, 400, 1);
        settle();
        check_stream("basic_stream");
        check_int("basic_frame_done", fd_cnt, 1);
        check_int("basic_sync_err", int'(sync_err), 0);
        check_int("basic_pix_ready", pr_cnt, N);
    endtask

    task automatic test_vblank_priority();
        clear();
        vblank = 1;
        cq.push_back({1'b0, 9'h036});
        cq.push_back({1'b1, 9'h128});
        push_frame(1, 0);
        model();
        exp.push_front(9'h128);
        exp.push_front(9'h036);
        drive(0, 0, 400, 1);
        settle();
        vblank = 0;
        check_stream("vblank_stream");
        check_int("vblank_frame_done", fd_cnt, exp_fd);
    endtask

    task automatic test_resync();
        clear();
        for (int i = 0; i < 3; i++) pq.push_back({1'(i == 0), 16'h1230 + 16'(i)});
        push_frame(0, 16'hA000);
        model();
        drive(0, 0, 400, 1);
        settle();
        check_stream("resync_stream");
        check_int("resync_sync_err", int'(sync_err), 1);
        check_int("resync_frame_done", fd_cnt, 1);
        clear_err();
        #1;
        check_int("err_clr", int'(sync_err), 0);
    endtask

    task automatic test_stall();
        clear();
        push_frame(1, 0);
        model();
        drive(2, 0, 400, 1);
        settle();
        check_stream("stall_stream");
        check_int("stall_stability", stab_err, 0);
        check_int("stall_pix_ready", pr_cnt, N);
        check_int("stall_frame_done", fd_cnt, 1);
    endtask

    task automatic test_reset_mid();
        clear();
        push_frame(1, 0);
        drive(0, 0, 16, 0);
        #1;
        check_int("pre_reset_busy", int'(bus_valid), 1);
        rst_n = 0;
        pix_valid = 0;
        pix_sof = 0;
        #1;
        tests++;
        if (bus_valid !== 1'b0 || bus_data !== 9'h0) begin
            fails++;
            $display("FAIL reset_mid: bus_valid %b bus_data %h required 0 and 000", bus_valid, bus_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        clear();
        push_frame(1, 0);
        model();
        drive(0, 0, 400, 1);
        settle();
        check_stream("post_reset_stream");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear();
            if ($urandom_range(0, 1) == 1) pq.push_back({1'b0, 16'($urandom)});
            push_frame(1, 0);
            model();
            drive(1, 1, 2000, 1);
            settle();
            check_stream("random_stream");
            check_int("random_frame_done", fd_cnt, exp_fd);
            check_int("random_sync_err", int'(sync_err), int'(exp_err));
            clear_err();
        end
    endtask

    initial begin
        test_reset();
        test_enable_low();
        test_basic_frame();
        test_vblank_priority();
        test_resync();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
